// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for an RV32I-style datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for each instruction.
// Any unsupported opcode parks the FSM in TRAP until reset.
// Outputs are decoded from the state register, the latched opcode and the
// two handshake inputs (mem_ready in FETCH/MEM, br_cond in EXEC).
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_cond,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       pc_we,
    output logic       pc_src,
    output logic       ir_we,
    output logic       memread,
    output logic       memwrite,
    output logic       regwr,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [1:0] wb_sel,
    output logic       instr_done,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int NUM_SUPPORTED = 9;
    localparam logic [7*NUM_SUPPORTED-1:0] SUPPORTED = {
        OP_AUIPC, OP_LUI, OP_JALR, OP_JAL, OP_BRANCH,
        OP_OPIMM, OP_OP, OP_STORE, OP_LOAD
    };

    state_t     state_reg;
    logic [6:0] op_q;
    logic       blank_reg;     // high in the cycle right after a reset edge
    logic       illegal_reg;

    logic [NUM_SUPPORTED-1:0] sup_hit;
    logic                     opcode_ok;

    // One comparator per supported opcode; DECODE only needs the OR.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SUPPORTED; gi++) begin : g_sup
            assign sup_hit[gi] = (opcode == SUPPORTED[gi*7 +: 7]);
        end
    endgenerate
    assign opcode_ok = |sup_hit;

    // Instruction class of the latched opcode, used from EXEC onward.
    logic is_load, is_store, is_op, is_branch, is_jal, is_jalr, is_auipc;
    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);
    assign is_op     = (op_q == OP_OP);
    assign is_branch = (op_q == OP_BRANCH);
    assign is_jal    = (op_q == OP_JAL);
    assign is_jalr   = (op_q == OP_JALR);
    assign is_auipc  = (op_q == OP_AUIPC);

    // State transitions, opcode latch, sticky illegal flag and the
    // post-reset blanking flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            op_q        <= '0;
            blank_reg   <= 1'b1;
            illegal_reg <= 1'b0;
        end else begin
            blank_reg <= 1'b0;
            case (state_reg)
                // No request is issued while blanked, so a stray mem_ready
                // in that cycle must not advance the FSM.
                S_FETCH: if (!blank_reg && mem_ready) state_reg <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    if (opcode_ok) begin
                        state_reg <= S_EXEC;
                    end else begin
                        state_reg   <= S_TRAP;
                        illegal_reg <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store) state_reg <= S_MEM;
                    else if (is_branch)      state_reg <= S_FETCH;
                    else                     state_reg <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) state_reg <= is_store ? S_FETCH : S_WB;
                end
                S_WB:    state_reg <= S_FETCH;
                S_TRAP:  state_reg <= S_TRAP;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    // Datapath controls decoded from state, op_q and handshake inputs.
    always_comb begin
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        ir_we      = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        regwr      = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        wb_sel     = 2'd0;
        instr_done = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (!blank_reg) begin
                    memread = 1'b1;
                    ir_we   = mem_ready;
                end
            end
            S_EXEC: begin
                alu_src_a = is_jal || is_auipc;
                alu_src_b = !(is_op || is_branch);
                if (is_branch) begin
                    pc_we      = 1'b1;
                    pc_src     = br_cond;
                    instr_done = 1'b1;
                end
            end
            S_MEM: begin
                memread  = is_load;
                memwrite = is_store;
                if (is_store && mem_ready) begin
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
            end
            S_WB: begin
                regwr      = 1'b1;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                pc_src     = is_jal || is_jalr;
                if (is_load)                wb_sel = 2'd1;
                else if (is_jal || is_jalr) wb_sel = 2'd2;
                else                        wb_sel = 2'd0;
            end
            default: ;
        endcase
    end

    assign state   = state_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed and random instructions checked
// cycle by cycle against per-instruction expectations built from the
// instruction-class rules, plus retirement latency.
module tb_multicycle_ctrl;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       br_cond;
    logic       mem_ready;
    logic [2:0] state;
    logic       pc_we, pc_src, ir_we, memread, memwrite, regwr;
    logic       alu_src_a, alu_src_b, instr_done, illegal;
    logic [1:0] wb_sel;

    logic [14:0] obs;
    int checks = 0;
    int errors = 0;
    int cyc_idx, done_at, done_cnt;
    logic [6:0] sup_ops [9] = '{LOAD, STORE, OPR, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC};

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .br_cond(br_cond),
        .mem_ready(mem_ready), .state(state), .pc_we(pc_we), .pc_src(pc_src),
        .ir_we(ir_we), .memread(memread), .memwrite(memwrite), .regwr(regwr),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign obs = {state, pc_we, pc_src, ir_we, memread, memwrite, regwr,
                  alu_src_a, alu_src_b, wb_sel, instr_done, illegal};

    function automatic logic [14:0] mk(input logic [2:0] st,
                                       input logic pcwe, pcsrc, irwe, mrd, mwr, rw, a, b,
                                       input logic [1:0] wbs,
                                       input logic done, ill);
        return {st, pcwe, pcsrc, irwe, mrd, mwr, rw, a, b, wbs, done, ill};
    endfunction

    // Inputs are already applied for this cycle; sample mid-cycle, then
    // step past the next rising edge.
    task automatic chk(input string tag, input logic [14:0] exp);
        @(negedge clk);
        checks++;
        cyc_idx++;
        if (instr_done === 1'b1) begin
            done_cnt++;
            done_at = cyc_idx;
        end
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic br,
                             input int fw, input int mw, input logic abort);
        logic ld, st, brn, jmp, pa, breg, ok;
        logic [1:0] wbs;
        int lat;
        ld   = (op == LOAD);
        st   = (op == STORE);
        brn  = (op == BRANCH);
        jmp  = (op == JAL) || (op == JALR);
        pa   = (op == JAL) || (op == AUIPC);
        breg = (op == OPR) || (op == BRANCH);
        ok   = 1'b0;
        for (int k = 0; k < 9; k++) if (sup_ops[k] == op) ok = 1'b1;
        wbs  = ld ? 2'd1 : (jmp ? 2'd2 : 2'd0);
        cyc_idx = 0; done_cnt = 0; done_at = 0;

        // Fetch: opcode is not yet meaningful.
        opcode = 7'($urandom);
        for (int i = 0; i < fw; i++) begin
            mem_ready = 1'b0;
            br_cond = 1'($urandom_range(0, 1));
            chk("fetch_wait", mk(3'd0, 0,0,0,1,0,0,0,0, 2'd0, 0,0));
        end
        mem_ready = 1'b1;
        chk("fetch", mk(3'd0, 0,0,1,1,0,0,0,0, 2'd0, 0,0));

        opcode = op;
        mem_ready = 1'($urandom_range(0, 1));
        chk("decode", mk(3'd1, 0,0,0,0,0,0,0,0, 2'd0, 0,0));

        if (!ok) begin
            for (int i = 0; i < 12; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                opcode = 7'($urandom);
                chk("trap", mk(3'd5, 0,0,0,0,0,0,0,0, 2'd0, 0,1));
            end
            rst = 1'b1;
            chk("trap_rst", mk(3'd5, 0,0,0,0,0,0,0,0, 2'd0, 0,1));
            rst = 1'b0;
            mem_ready = 1'b1;
            chk("after_trap_rst", mk(3'd0, 0,0,0,0,0,0,0,0, 2'd0, 0,0));
            $display("instr op=%b illegal, trapped then reset", op);
            return;
        end

        // Opcode input is scrambled from here on: the latched copy must rule.
        opcode = 7'($urandom);
        br_cond = br;
        mem_ready = 1'($urandom_range(0, 1));
        chk("exec", mk(3'd2, brn, brn & br, 0,0,0,0, pa, !breg, 2'd0, brn, 0));

        if (ld || st) begin
            for (int i = 0; i < mw; i++) begin
                mem_ready = 1'b0;
                if (abort && i == 0) begin
                    rst = 1'b1;
                    chk("mem_rst", mk(3'd3, 0,0,0,ld,st,0,0,0, 2'd0, 0,0));
                    rst = 1'b0;
                    mem_ready = 1'b1;
                    chk("after_mem_rst", mk(3'd0, 0,0,0,0,0,0,0,0, 2'd0, 0,0));
                    $display("instr op=%b aborted by reset in MEM", op);
                    return;
                end
                chk("mem_wait", mk(3'd3, 0,0,0,ld,st,0,0,0, 2'd0, 0,0));
            end
            mem_ready = 1'b1;
            chk("mem", mk(3'd3, st,0,0,ld,st,0,0,0, 2'd0, st,0));
        end

        if (!brn && !st) begin
            mem_ready = 1'($urandom_range(0, 1));
            chk("wb", mk(3'd4, 1,jmp,0,0,0,1,0,0, wbs, 1,0));
        end

        lat = (ld ? 5 : (brn ? 3 : 4)) + fw + ((ld || st) ? mw : 0);
        checks++;
        assert (done_cnt == 1 && done_at == lat) else begin
            errors++;
            $error("FAIL latency observed=%0d pulses=%0d expected=%0d pulses=1",
                   done_at, done_cnt, lat);
        end
        $display("instr op=%b br=%0d fetch_wait=%0d mem_wait=%0d retired_at=%0d",
                 op, br, fw, mw, done_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        rst = 1'b1;
        opcode = '0;
        br_cond = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_hold", mk(3'd0, 0,0,0,0,0,0,0,0, 2'd0, 0,0));
        rst = 1'b0;
        chk("reset_release", mk(3'd0, 0,0,0,0,0,0,0,0, 2'd0, 0,0));

        run_instr(LOAD,   1'b0, 0, 0, 1'b0);
        run_instr(STORE,  1'b0, 0, 2, 1'b0);
        run_instr(BRANCH, 1'b1, 0, 0, 1'b0);
        run_instr(BRANCH, 1'b0, 0, 0, 1'b0);
        run_instr(JAL,    1'b0, 0, 0, 1'b0);
        run_instr(7'b1111111, 1'b0, 0, 0, 1'b0);
        run_instr(LOAD,   1'b0, 1, 2, 1'b1);
        run_instr(OPR,    1'b0, 2, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            op = sup_ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = 7'b0000000;
            run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
